// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes, and Status/Cause field
// positions used by the register file and its timer.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_BEV = 22;

  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] STATUS_BEV   = 32'h0040_0000;

  // Register-number decode shared by the MTC0 write and MFC0 read paths.
  function automatic logic cp0_hit(input logic [4:0] addr, input logic [2:0] sel,
                                   input logic [4:0] num);
    return (sel == 3'd0) && (addr == num);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances once every COUNT_DIV cycles and TI
// latches on a Count==Compare match until Compare is rewritten.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic             ti_q, ti_d;
  logic             armed_q, armed_d;
  logic             tick;
  logic             match;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    tick      = (COUNT_DIV == 1) || (div_q == DIV_W'(COUNT_DIV - 1));
    match     = armed_q && (count_q == compare_q);
    div_d     = tick ? '0 : div_q + 1'b1;
    count_d   = tick ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    ti_d      = ti_q | match;
    armed_d   = armed_q | count_we_i | compare_we_i;
    if (count_we_i) begin
      count_d = wdata_i;
      div_d   = '0;
    end
    // A Compare write clears TI even if a match lands on the same edge.
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end
  end

  // The reset state (0,0) is a match; armed suppresses it until software
  // has written Count or Compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
      armed_q   <= armed_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: absorbs committed exceptions/ERET, serves
// MTC0/MFC0, and exports Status/Cause/EPC/BadVAddr plus the interrupt request.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 2,
  parameter int unsigned TIMER_IP  = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_epc,
  input  logic        exc_bd,
  input  logic        exc_badv_we,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [2:0]  mtc0_sel,
  input  logic [31:0] mtc0_wdata,
  input  logic [4:0]  mfc0_addr,
  input  logic [2:0]  mfc0_sel,
  output logic [31:0] mfc0_rdata,
  input  logic [5:0]  hw_int,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic [31:0] badvaddr,
  output logic        int_pending,
  output logic        timer_int
);

  localparam int TI_IDX = int'(TIMER_IP) - 2;

  logic [31:0] status_q, status_d;
  logic [1:0]  sw_ip_q, sw_ip_d;
  logic [5:0]  hw_ip_q;
  logic [4:0]  exccode_q, exccode_d;
  logic        bd_q, bd_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count, compare;
  logic        ti;
  logic [5:0]  ip_hw;
  logic        wr_status, wr_cause, wr_epc, wr_count, wr_compare;

  assign wr_status  = mtc0_we && cp0_hit(mtc0_addr, mtc0_sel, CP0_STATUS);
  assign wr_cause   = mtc0_we && cp0_hit(mtc0_addr, mtc0_sel, CP0_CAUSE);
  assign wr_epc     = mtc0_we && cp0_hit(mtc0_addr, mtc0_sel, CP0_EPC);
  assign wr_count   = mtc0_we && cp0_hit(mtc0_addr, mtc0_sel, CP0_COUNT);
  assign wr_compare = mtc0_we && cp0_hit(mtc0_addr, mtc0_sel, CP0_COMPARE);

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (wr_count),
    .compare_we_i (wr_compare),
    .wdata_i      (mtc0_wdata),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  // Field-level priority: exception over ERET over MTC0 on the same field.
  // BadVAddr is read-only to software and only changes on an exception.
  always_comb begin
    status_d   = wr_status ? (mtc0_wdata & STATUS_WMASK) : status_q;
    sw_ip_d    = wr_cause ? mtc0_wdata[CA_IP_LO+1:CA_IP_LO] : sw_ip_q;
    epc_d      = wr_epc ? mtc0_wdata : epc_q;
    exccode_d  = exccode_q;
    bd_d       = bd_q;
    badvaddr_d = badvaddr_q;
    if (exc_valid) begin
      status_d[ST_EXL] = 1'b1;
      exccode_d        = exc_code;
      bd_d             = exc_bd;
      epc_d            = exc_epc;
      if (exc_badv_we) badvaddr_d = exc_badvaddr;
    end else if (eret) begin
      status_d[ST_EXL] = 1'b0;
    end
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= '0;
      sw_ip_q    <= '0;
      hw_ip_q    <= '0;
      exccode_q  <= '0;
      bd_q       <= 1'b0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      status_q   <= status_d;
      sw_ip_q    <= sw_ip_d;
      hw_ip_q    <= hw_int;
      exccode_q  <= exccode_d;
      bd_q       <= bd_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // The timer interrupt takes over one hardware IP line.
  always_comb begin
    ip_hw         = hw_ip_q;
    ip_hw[TI_IDX] = ti;
  end

  assign status   = status_q | STATUS_BEV;
  assign cause    = {bd_q, ti, 14'd0, ip_hw, sw_ip_q, 1'b0, exccode_q, 2'b00};
  assign epc      = epc_q;
  assign badvaddr = badvaddr_q;
  assign timer_int = ti;
  assign int_pending = (|(cause[15:8] & status[15:8])) & status[ST_IE] & ~status[ST_EXL];

  always_comb begin
    mfc0_rdata = '0;
    if (mfc0_sel == 3'd0) begin
      case (mfc0_addr)
        CP0_BADVADDR: mfc0_rdata = badvaddr;
        CP0_COUNT:    mfc0_rdata = count;
        CP0_COMPARE:  mfc0_rdata = compare;
        CP0_STATUS:   mfc0_rdata = status;
        CP0_CAUSE:    mfc0_rdata = cause;
        CP0_EPC:      mfc0_rdata = epc;
        default:      mfc0_rdata = '0;
      endcase
    end
  end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file: the consumer end of the exception path.
- Absorbs committed exception and ERET events from the writeback-stage exception logic, serves MTC0/MFC0, runs the Count/Compare timer and samples interrupt lines.
- Drives Status/Cause/EPC back to exception detection and the PC-redirect logic.

Parameters:
- COUNT_DIV, 2, cycles per Count increment (power of two, ≥1).
- TIMER_IP, 7, Cause.IP bit that carries the timer interrupt; it replaces hw_int[TIMER_IP-2] in Cause.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- exc_valid  in  1  exception commits this cycle
- exc_code  in  5  ExcCode to record
- exc_epc  in  32  EPC value to record
- exc_bd  in  1  faulting instruction is in a delay slot
- exc_badv_we  in  1  update BadVAddr with this exception
- exc_badvaddr  in  32  faulting address
- eret  in  1  ERET commits this cycle (ignored if exc_valid)
- mtc0_we  in  1  MTC0 write strobe
- mtc0_addr  in  5  destination register number
- mtc0_sel  in  3  select field
- mtc0_wdata  in  32  write data
- mfc0_addr  in  5  read register number
- mfc0_sel  in  3  read select
- mfc0_rdata  out  32  read data, combinational
- hw_int  in  6  external interrupt lines, level-sensitive
- status  out  32  Status register
- cause  out  32  Cause register
- epc  out  32  EPC register
- badvaddr  out  32  BadVAddr register
- int_pending  out  1  |(Cause.IP & Status.IM) & IE & ~EXL
- timer_int  out  1  Cause.TI

Behaviour:
- Registers implemented:
  - BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), all sel 0.
  - Any other addr or sel≠0: reads return 0, writes are dropped.
- Reset:
  - Status=0x0040_0000 (BEV=1), all other registers 0.
  - Internal divider counter 0.
  - Outputs reflect register values.
- Status:
  - Writable bits are IM[15:8], EXL[1] and IE[0].
  - BEV reads 1; all other bits read 0.
- Cause:
  - Only IP[9:8] (software interrupts) is MTC0-writable.
  - IP[15:10] is registered each cycle from hw_int, except that bit TIMER_IP+8 = TI.
  - TI = bit 30, BD = bit 31, ExcCode = bits[6:2].
- Timer:
  - Count increments by 1 every COUNT_DIV cycles and wraps at 2^32.
  - TI sets on the cycle after Count==Compare, with Compare≠0 or Count≠0 after any write.
  - TI stays set until Compare is written.
  - MTC0 to Count reloads Count and resets the divider.
  - MTC0 to Compare clears TI in the same edge.
  - If Count==Compare coincides with a Compare write, the clear wins.
- Exception commit (exc_valid=1), at the next edge:
  - EXL←1, Cause.ExcCode←exc_code, Cause.BD←exc_bd, EPC←exc_epc.
  - BadVAddr←exc_badvaddr if exc_badv_we.
  - This block does not re-gate on EXL; the producer already does.
- ERET (eret=1, exc_valid=0): EXL←0 at the next edge.
- Priority on the same field in the same cycle: exception > ERET > MTC0.
  - MTC0 to a field not touched by the exception or ERET still takes effect.
  - Example: exception plus MTC0 Compare writes both.
- Read-after-write:
  - mfc0_rdata reads current register state, with no bypass.
  - The pipeline guarantees MTC0→MFC0 ordering with one cycle of separation.
- Reset mid-operation overrides every write source and every timer event.

Decomposition:
- Shared package cp0_pkg:
  - register-number constants (CP0_BADVADDR=8, CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14)
  - ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12)
  - Status/Cause bit-position constants and the Status write mask.
- One natural sub-module: cp0_timer (Count, Compare, divider, TI), with ports for the Count/Compare write strobes and data.

Test Plan:
1. Assert rst 2 cycles → status=0x00400000; cause, epc, badvaddr, count=0; mfc0 addr 12 → 0x00400000.
2. MTC0 Status=0xFFFFFFFF, then MFC0 12 → 0x0040FF03. MTC0 Cause=0xFFFFFFFF → cause=0x00000300.
3. exc_valid, exc_code=5, exc_epc=0xBFC00100, exc_bd=1, exc_badv_we=1, badvaddr=0x1001 → next cycle cause=0x80000014, EXL=1, epc=0xBFC00100, badvaddr=0x1001. Then eret → EXL=0, epc unchanged.
4. MTC0 Compare=10, Count=0, COUNT_DIV=2 → timer_int rises 21 cycles later; cause bit 15 set. With Status=0x00008001 → int_pending=1. MTC0 Compare → timer_int clears next edge.
5. Same cycle: exc_valid plus eret plus MTC0 Status=0 → EXL=1, IM/IE=0. Same cycle: exc_valid plus MTC0 EPC=0x1234 → epc=exc_epc.
6. hw_int=6'b000001 with Status=0x00000401 → cause IP2 set next cycle, int_pending=1. Set EXL via exception → int_pending=0.
